mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Multi-cycle data-memory sequencer for the MEM stage of the 5-stage pipeline.
- On a load or store held in EX/MEM, it drives a req/ack handshake to the data memory and stalls the front of the pipeline until the access completes.
- While stalled, it forces a bubble into MEM/WB. On completion it presents the load data to MEM/WB.
- It bounds each access with a timeout.

Parameters:
- TIMEOUT, 64, maximum number of BUSY cycles waiting for mem_ack_i before the access is aborted (must be ≥1).
- CNT_W, $clog2(TIMEOUT+1), width of the wait counter.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous reset, active-low.
- MemRead_i  in  1  load in MEM stage (from EX/MEM).
- MemWrite_i  in  1  store in MEM stage (from EX/MEM).
- addr_i  in  32  ALU result / effective address.
- wdata_i  in  32  store data.
- mem_ack_i  in  1  memory completion strobe.
- mem_rdata_i  in  32  memory read data, valid with mem_ack_i.
- mem_req_o  out  1  memory request, level, held until ack or timeout.
- mem_we_o  out  1  1 = write access.
- mem_addr_o  out  32  latched address.
- mem_wdata_o  out  32  latched store data.
- stall_o  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- wb_bubble_o  out  1  forces RegWrite/MemtoReg to 0 into MEM/WB.
- Memdata_o  out  32  load data to MEM/WB.
- err_o  out  1  sticky timeout flag.
- perf_stall_cnt_o  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset: when rst_i=0 at a posedge, state←IDLE and counter←0. After that edge every output is 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, Memdata_o, err_o, perf_stall_cnt_o.
- States: IDLE, BUSY, DONE.
- Access request: acc = MemRead_i | MemWrite_i.

IDLE:
- If acc: latch mem_addr_o←addr_i and mem_wdata_o←wdata_i.
- Set mem_we_o←MemWrite_i. If both MemRead_i and MemWrite_i are high, the write wins.
- Counter←0, go to BUSY.
- mem_ack_i is ignored in IDLE.

BUSY:
- mem_req_o=1.
- If mem_ack_i: go to DONE. On a read, Memdata_o←mem_rdata_i; on a write, Memdata_o is unchanged.
- Else if counter==TIMEOUT-1: go to DONE, Memdata_o←32'hDEAD_BEEF on a read, err_o←1.
- Else counter←counter+1.

DONE:
- Lasts one cycle, then go to IDLE unconditionally.
- The access still sitting in EX/MEM is consumed by this cycle and must not restart.
- mem_req_o=0; mem_ack_i is ignored.

Output decode:
- stall_o = (IDLE & acc) | BUSY. This is combinational in IDLE so the pipeline holds the same cycle the access arrives.
- wb_bubble_o = stall_o. MEM/WB has no enable, so the bubble prevents a premature or duplicate write-back.
- mem_req_o = (state==BUSY), registered state decode.

Latency and boundary conditions:
- Request seen in IDLE at cycle t → mem_req_o high at t+1.
- Ack sampled at cycle k → DONE at k+1, with Memdata_o valid and stall_o=0.
- Minimum stall is 2 cycles (ack in the first BUSY cycle). Maximum stall is TIMEOUT+1 cycles.
- Back-to-back memory instructions: the next one arrives in IDLE the cycle after DONE, and one unstalled cycle separates the two stalls.
- Reset mid-BUSY: mem_req_o=0 after the reset edge; the pending access is dropped.
- err_o is cleared only by reset.

Optional Feature:
- Macro: MEMCTRL_PERF_EN.
- With the macro defined: perf_stall_cnt_o increments by 1 on every cycle with stall_o=1 and wraps at 2^32. It resets to 0.
- Without the macro: perf_stall_cnt_o is tied to 32'h0 and no counter logic is generated.

Test Plan:
- Load, ack after 3 BUSY cycles: MemRead_i=1, addr_i=0x100, ack with mem_rdata_i=0x12345678 → mem_req_o high for 3 cycles, mem_addr_o=0x100, mem_we_o=0, stall_o high for 4 cycles, Memdata_o=0x12345678 in DONE, wb_bubble_o low in DONE.
- Store, ack in first BUSY cycle: MemWrite_i=1, addr_i=0x20, wdata_i=0xCAFEF00D → mem_we_o=1, mem_wdata_o=0xCAFEF00D, stall_o high for exactly 2 cycles, Memdata_o unchanged.
- Timeout with TIMEOUT=4 and no ack on a load → mem_req_o high for 4 cycles, then DONE with Memdata_o=0xDEADBEEF, err_o=1, and err_o remains 1 across subsequent accesses.
- Read and write asserted together → write access issued (mem_we_o=1); a late ack arriving in IDLE causes no state change.
- Reset mid-BUSY: rst_i=0 in the 2nd BUSY cycle → mem_req_o=0, stall_o=0, state IDLE the next cycle; a new load after reset completes normally.
- MEMCTRL_PERF_EN defined: two loads with stalls of 4 and 2 cycles → perf_stall_cnt_o=6.
- MEMCTRL_PERF_EN undefined: the same two loads leave perf_stall_cnt_o=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake, pipeline stall/bubble, timeout abort.
// Optional stall-cycle performance counter enabled by defining MEMCTRL_PERF_EN.
//
// state | meaning
// IDLE  | no access in flight; a new load/store is latched and stalls combinationally
// BUSY  | mem_req_o held, waiting for mem_ack_i or wait-timer terminal count
// DONE  | one-cycle completion; Memdata_o valid, pipeline released
module mem_access_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        stall_o,
    output logic        wb_bubble_o,
    output logic [31:0] Memdata_o,
    output logic        err_o,
    output logic [31:0] perf_stall_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic             acc;

    assign acc = MemRead_i | MemWrite_i;

    // The wait timer counts down from TIMEOUT-1; reaching zero without an ack aborts the access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = MemWrite_i;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ack_i) begin
                    state_d = S_DONE;
                    if (!we_q) rdata_d = mem_rdata_i;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = 32'hDEAD_BEEF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Stall must assert in the arrival cycle, so the IDLE term is combinational on the inputs.
    assign stall_o     = ((state_q == S_IDLE) && acc) || (state_q == S_BUSY);
    assign wb_bubble_o = stall_o;
    assign mem_req_o   = (state_q == S_BUSY);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign Memdata_o   = rdata_q;
    assign err_o       = err_q;

`ifdef MEMCTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_q <= '0;
        end else if (stall_o) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_q;
`else
    assign perf_stall_cnt_o = 32'h0;
`endif

endmodule
